// File: rtl/brtag_manager_pkg.sv
// Shared definitions for the branch-tag manager: default widths and the
// opcodes that dispatch uses to decide whether a uop needs a branch tag.
package brtag_manager_pkg;

    localparam int BRM_WIDTH_DEF = 4;
    localparam int PC_WIDTH_DEF  = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic needs_brtag(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/brtag_manager_if.sv
// Bundle between dispatch/executeBR (master) and the branch-tag manager (slave).
interface brtag_manager_if
    import brtag_manager_pkg::*;
#(
    parameter int WIDTH_BRM = BRM_WIDTH_DEF,
    parameter int WIDTH_PC  = PC_WIDTH_DEF
);
    logic                 i_flush;
    logic                 i_alloc_req;
    logic                 o_alloc_ok;
    logic [WIDTH_BRM-1:0] o_tag;
    logic [WIDTH_BRM-1:0] o_brmask;
    logic                 i_res_valid;
    logic [WIDTH_BRM-1:0] i_res_tag;
    logic                 i_res_kill;
    logic [WIDTH_PC-1:0]  i_res_PC;
    logic [WIDTH_BRM-1:0] o_clr_mask;
    logic [WIDTH_BRM-1:0] o_kill_mask;
    logic                 o_redirect_valid;
    logic [WIDTH_PC-1:0]  o_redirect_PC;
    logic [31:0]          o_cnt_res;
    logic [31:0]          o_cnt_kill;

    modport master (
        output i_flush, i_alloc_req, i_res_valid, i_res_tag, i_res_kill, i_res_PC,
        input  o_alloc_ok, o_tag, o_brmask, o_clr_mask, o_kill_mask,
               o_redirect_valid, o_redirect_PC, o_cnt_res, o_cnt_kill
    );

    modport slave (
        input  i_flush, i_alloc_req, i_res_valid, i_res_tag, i_res_kill, i_res_PC,
        output o_alloc_ok, o_tag, o_brmask, o_clr_mask, o_kill_mask,
               o_redirect_valid, o_redirect_PC, o_cnt_res, o_cnt_kill
    );

endinterface

// File: rtl/brtag_manager_onehot_lowest.sv
// Isolates the lowest set bit of a vector as a one-hot value (0 when the input is 0).
module onehot_lowest #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [WIDTH-1:0] onehot_o
);

    assign onehot_o = vec_i & (~vec_i + WIDTH'(1));

endmodule

// File: rtl/brtag_manager.sv
// Branch-tag owner: grants one-hot tags, tracks per-tag dependency snapshots and
// broadcasts clear/kill masks and fetch redirects. Perf counters under BRTAG_PERF_EN.
module brtag_manager
    import brtag_manager_pkg::*;
#(
    parameter int WIDTH_BRM = BRM_WIDTH_DEF,
    parameter int WIDTH_PC  = PC_WIDTH_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    brtag_manager_if.slave  bus
);

    logic [WIDTH_BRM-1:0] busy_q, busy_d;
    logic [WIDTH_BRM-1:0] dep_q [WIDTH_BRM];
    logic [WIDTH_BRM-1:0] dep_d [WIDTH_BRM];
    logic [WIDTH_BRM-1:0] clr_q, clr_d;
    logic [WIDTH_BRM-1:0] kill_q, kill_d;
    logic                 redir_q, redir_d;
    logic [WIDTH_PC-1:0]  redir_pc_q, redir_pc_d;

    logic [WIDTH_BRM-1:0] low_free;
    logic [WIDTH_BRM-1:0] grant_tag;
    logic [WIDTH_BRM-1:0] res_hit_tag;
    logic [WIDTH_BRM-1:0] kill_set;
    logic                 kill_req;
    logic                 res_hit;
    logic                 alloc_ok;
    logic                 res_ok_evt;
    logic                 kill_evt;

    onehot_lowest #(.WIDTH(WIDTH_BRM)) u_lowest (
        .vec_i    (~busy_q),
        .onehot_o (low_free)
    );

    assign kill_req    = bus.i_res_valid & bus.i_res_kill;
    assign res_hit_tag = bus.i_res_tag & busy_q;
    assign res_hit     = bus.i_res_valid & (|res_hit_tag);
    // A kill request blocks allocation even when its tag turns out not to be live.
    assign alloc_ok    = bus.i_alloc_req & (|(~busy_q)) & ~bus.i_flush & ~kill_req;
    assign grant_tag   = alloc_ok ? low_free : '0;
    assign res_ok_evt  = ~bus.i_flush & res_hit & ~bus.i_res_kill;
    assign kill_evt    = ~bus.i_flush & res_hit & bus.i_res_kill;

    // Squash set: the resolving tag plus every live tag allocated while it was live.
    always_comb begin
        kill_set = res_hit_tag;
        for (int u = 0; u < WIDTH_BRM; u++) begin
            if (|(dep_q[u] & bus.i_res_tag)) kill_set[u] = 1'b1;
        end
        kill_set = kill_set & busy_q;
    end

    always_comb begin
        busy_d     = busy_q;
        dep_d      = dep_q;
        clr_d      = '0;
        kill_d     = '0;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc_q;
        if (bus.i_flush) begin
            busy_d = '0;
            kill_d = busy_q;
            for (int u = 0; u < WIDTH_BRM; u++) dep_d[u] = '0;
        end else if (kill_evt) begin
            busy_d     = busy_q & ~kill_set;
            kill_d     = kill_set;
            redir_d    = 1'b1;
            redir_pc_d = bus.i_res_PC;
            for (int u = 0; u < WIDTH_BRM; u++) dep_d[u] = dep_q[u] & ~kill_set;
        end else begin
            if (res_ok_evt) begin
                busy_d = busy_q & ~res_hit_tag;
                clr_d  = res_hit_tag;
                for (int u = 0; u < WIDTH_BRM; u++) dep_d[u] = dep_q[u] & ~res_hit_tag;
            end
            if (alloc_ok) begin
                busy_d = busy_d | grant_tag;
                for (int u = 0; u < WIDTH_BRM; u++) begin
                    if (grant_tag[u]) dep_d[u] = busy_q & ~clr_d;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q     <= '0;
            clr_q      <= '0;
            kill_q     <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            for (int u = 0; u < WIDTH_BRM; u++) dep_q[u] <= '0;
        end else begin
            busy_q     <= busy_d;
            clr_q      <= clr_d;
            kill_q     <= kill_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            for (int u = 0; u < WIDTH_BRM; u++) dep_q[u] <= dep_d[u];
        end
    end

`ifdef BRTAG_PERF_EN
    logic [31:0] cnt_res_q, cnt_kill_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_res_q  <= '0;
            cnt_kill_q <= '0;
        end else begin
            if (res_ok_evt) cnt_res_q  <= cnt_res_q + 32'd1;
            if (kill_evt)   cnt_kill_q <= cnt_kill_q + 32'd1;
        end
    end

    assign bus.o_cnt_res  = cnt_res_q;
    assign bus.o_cnt_kill = cnt_kill_q;
`else
    assign bus.o_cnt_res  = 32'd0;
    assign bus.o_cnt_kill = 32'd0;
`endif

    assign bus.o_alloc_ok       = alloc_ok;
    assign bus.o_tag            = grant_tag;
    assign bus.o_brmask         = busy_q;
    assign bus.o_clr_mask       = clr_q;
    assign bus.o_kill_mask      = kill_q;
    assign bus.o_redirect_valid = redir_q;
    assign bus.o_redirect_PC    = redir_pc_q;

endmodule
